// File: rtl/usbfs_serial_reg_bridge.sv
// Byte-stream to register-bus bridge behind the USB full-speed serial block.
// Host sends cmd (bit7 write, low bits addr), LEN, then LEN+1 data bytes on a
// write; a read returns LEN+1 register bytes on the device-to-host stream.
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_hostToDev_valid/data        host byte stream in
//   o_hostToDev_ready             bridge accepts host byte
//   o_devToHost_valid/data        response byte stream out
//   i_devToHost_ready             serial block accepts response byte
//   o_bus_addr/wrEn/wrData/rdEn   single-cycle register bus
//   i_bus_rdData                  read data, valid the cycle after rdEn
//   o_busy, o_timeout             not idle / one-cycle abort pulse
module usbfs_serial_reg_bridge #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 4800000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hostToDev_valid,
    input  logic [7:0]        i_hostToDev_data,
    output logic              o_hostToDev_ready,
    output logic              o_devToHost_valid,
    output logic [7:0]        o_devToHost_data,
    input  logic              i_devToHost_ready,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_wrEn,
    output logic [7:0]        o_bus_wrData,
    output logic              o_bus_rdEn,
    input  logic [7:0]        i_bus_rdData,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_CAP  = 3'd4;
    localparam logic [2:0] S_RD_RESP = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        count;
    logic              isWrite;
    logic [IDLE_W-1:0] idleCnt;
    logic              hostAccept;
    logic              devAccept;
    logic              idleExpired;

    // Ready is a pure function of state, forced low while reset is held.
    assign o_hostToDev_ready = !i_rst &&
        (state == S_IDLE || state == S_LEN || state == S_WR);
    assign hostAccept  = i_hostToDev_valid && o_hostToDev_ready;
    assign devAccept   = o_devToHost_valid && i_devToHost_ready;
    assign idleExpired = (idleCnt == IDLE_LAST);
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= S_IDLE;
            addr              <= '0;
            count             <= '0;
            isWrite           <= 1'b0;
            idleCnt           <= '0;
            o_devToHost_valid <= 1'b0;
            o_devToHost_data  <= '0;
            o_bus_addr        <= '0;
            o_bus_wrEn        <= 1'b0;
            o_bus_wrData      <= '0;
            o_bus_rdEn        <= 1'b0;
            o_timeout         <= 1'b0;
        end else begin
            o_bus_wrEn <= 1'b0;
            o_bus_rdEn <= 1'b0;
            o_timeout  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    idleCnt <= '0;
                    if (hostAccept) begin
                        isWrite <= i_hostToDev_data[7];
                        addr    <= i_hostToDev_data[ADDR_W-1:0];
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (hostAccept) begin
                        count   <= i_hostToDev_data;
                        idleCnt <= '0;
                        if (isWrite) begin
                            state <= S_WR;
                        end else begin
                            // Strobe is registered so it lines up with RD_REQ.
                            state      <= S_RD_REQ;
                            o_bus_rdEn <= 1'b1;
                            o_bus_addr <= addr;
                        end
                    end else if (idleExpired) begin
                        state     <= S_IDLE;
                        o_timeout <= 1'b1;
                        idleCnt   <= '0;
                    end else begin
                        idleCnt <= idleCnt + 1'b1;
                    end
                end
                S_WR: begin
                    if (hostAccept) begin
                        o_bus_wrEn   <= 1'b1;
                        o_bus_addr   <= addr;
                        o_bus_wrData <= i_hostToDev_data;
                        addr         <= addr + 1'b1;
                        idleCnt      <= '0;
                        if (count == 8'd0) state <= S_IDLE;
                        else count <= count - 1'b1;
                    end else if (idleExpired) begin
                        state     <= S_IDLE;
                        o_timeout <= 1'b1;
                        idleCnt   <= '0;
                    end else begin
                        idleCnt <= idleCnt + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    o_devToHost_data  <= i_bus_rdData;
                    o_devToHost_valid <= 1'b1;
                    state             <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (devAccept) begin
                        o_devToHost_valid <= 1'b0;
                        addr              <= addr + 1'b1;
                        if (count == 8'd0) begin
                            state <= S_IDLE;
                        end else begin
                            count      <= count - 1'b1;
                            state      <= S_RD_REQ;
                            o_bus_rdEn <= 1'b1;
                            o_bus_addr <= addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
